axi_slv_wr_ctrl: RTL and testbench

- RTL AXI3 write-channel slave: accepts one write burst at a time on AW/W, stores data in an internal word memory, returns a B response.
- Sits directly downstream of the master-driver/interface stage: the DUT endpoint the AXI3 VIP master drives.
- A registered debug read port exposes memory contents to the bench.

---
 rtl/axi_slv_wr_ctrl_if.sv | 44 ++++
 rtl/axi_slv_wr_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_axi_slv_wr_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_wr_ctrl_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the master driver and the slave.
interface axi_slv_wr_ctrl_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awbrust;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrob;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awid, awaddr, awlen, awsize, awbrust, awvalid,
        input  awready,
        output wid, wdata, wstrob, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awbrust, awvalid,
        output awready,
        input  wid, wdata, wstrob, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_slv_wr_ctrl.sv
// AXI3 write slave: one burst at a time into a word memory, B response after
// the last beat, and a registered debug read port into the memory.
module axi_slv_wr_ctrl #(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              aclk,
    input  logic              arst,
    axi_slv_wr_ctrl_if.slave  bus,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_e;

    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_e state_q, state_d;

    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wrap_lo_q, wrap_lo_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [3:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [DATA_W-1:0] dbg_data_q;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic              aw_hs, w_hs, b_hs, last_beat;
    logic              aw_err, beat_err, mem_we;
    logic [ADDR_W-1:0] aw_wrap_len, beat_bytes, wrap_len, wrap_next, next_addr;

    assign aw_hs     = bus.awvalid && awready_q;
    assign w_hs      = bus.wvalid && wready_q;
    assign b_hs      = bvalid_q && bus.bready;
    assign last_beat = (beat_q == len_q);

    // Burst-shape errors are judged once, from the AW fields.
    assign aw_wrap_len = (ONE << bus.awsize) * (ADDR_W'(bus.awlen) + ONE);
    assign aw_err = (bus.awsize > 3'd2) || (bus.awbrust == 2'b11) ||
                    ((bus.awbrust == 2'b10) &&
                     !(bus.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

    // Beat errors suppress the current beat as well as the rest of the burst.
    assign beat_err = (addr_q >= MEM_BYTES) || (bus.wid != id_q) ||
                      (bus.wlast != last_beat);
    assign mem_we   = (state_q == S_DATA) && w_hs && !err_q && !beat_err;

    assign beat_bytes = ONE << size_q;
    assign wrap_len   = beat_bytes * (ADDR_W'(len_q) + ONE);
    assign wrap_next  = addr_q + beat_bytes;

    // Address of the following beat for each burst type.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = (addr_q & ~(beat_bytes - ONE)) + beat_bytes;
            2'b10:   next_addr = (wrap_next == wrap_lo_q + wrap_len) ? wrap_lo_q : wrap_next;
            default: next_addr = addr_q;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or posedge arst) begin
        // NOTE: clocked blocks use non-blocking assignments so all registers see pre-edge values.
        if (arst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: bursts always end on beat count, never on wlast.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (aw_hs)            state_d = S_DATA;
            S_DATA:  if (w_hs && last_beat) state_d = S_RESP;
            S_RESP:  if (b_hs)             state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Next values of the registered handshake outputs and burst context.
    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wrap_lo_d = wrap_lo_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    id_d      = bus.awid;
                    addr_d    = bus.awaddr;
                    wrap_lo_d = bus.awaddr & ~(aw_wrap_len - ONE);
                    len_d     = bus.awlen;
                    size_d    = bus.awsize;
                    burst_d   = bus.awbrust;
                    beat_d    = '0;
                    err_d     = aw_err;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 4'd1;
                    addr_d = next_addr;
                    err_d  = err_q || beat_err;
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (err_q || beat_err) ? 2'b10 : 2'b00;
                    end
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers, plus the debug read port.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= 2'b00;
            id_q       <= '0;
            addr_q     <= '0;
            wrap_lo_q  <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            wrap_lo_q  <= wrap_lo_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            dbg_data_q <= mem_q[dbg_addr];
        end
    end

    // Byte-lane memory write; strobes are used exactly as driven.
    always_ff @(posedge aclk) begin
        // NOTE: the memory is deliberately not reset; contents survive arst.
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrob[i]) mem_q[addr_q[IDX_W+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
    assign dbg_data    = dbg_data_q;
endmodule

// File: tb/tb_axi_slv_wr_ctrl.sv
// Bench for axi_slv_wr_ctrl: directed bursts, a word-level memory model with
// closed-form beat addresses, and a per-cycle compare of debug data and B fields.
module tb_axi_slv_wr_ctrl;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 256;

    logic        aclk;
    logic        arst;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    axi_slv_wr_ctrl_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_slv_wr_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .aclk     (aclk),
        .arst     (arst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [MEM_DEPTH];
    bit          known     [MEM_DEPTH];
    logic [31:0] b_data [16];
    logic [3:0]  b_strb [16];
    logic [3:0]  b_wid  [16];
    logic        b_last [16];
    logic [3:0]  exp_bid   = '0;
    logic [1:0]  exp_bresp = '0;
    bit          dbg_force = 1'b0;
    logic [7:0]  dbg_force_addr = '0;
    int          aw_n_last = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of beat i, computed directly from the burst definition.
    function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] size,
                                               input logic [3:0] len, input logic [1:0] burst,
                                               input int i);
        logic [31:0] nb, span, lower;
        nb = 32'd1 << size;
        case (burst)
            2'b01: return (i == 0) ? start : (start / nb) * nb + nb * 32'(i);
            2'b10: begin
                span  = nb * (32'(len) + 32'd1);
                lower = (start / span) * span;
                return lower + ((start - lower) + nb * 32'(i)) % span;
            end
            default: return start;
        endcase
    endfunction

    task automatic prep(input logic [3:0] id, input logic [3:0] len, input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            b_data[i] = base + 32'(i);
            b_strb[i] = 4'hF;
            b_wid[i]  = id;
            b_last[i] = (i == int'(len));
        end
    endtask

    task automatic model_write(input int i, input logic [31:0] a);
        logic [7:0] w;
        w = a[9:2];
        for (int l = 0; l < 4; l++) begin
            if (b_strb[i][l]) model_mem[w][8*l +: 8] = b_data[i][8*l +: 8];
        end
        known[w] = 1'b1;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awbrust = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        aw_n_last = n;
        ok = (bus.awready === 1'b1);
        if (!ok) begin
            check("aw_timeout", {31'd0, bus.awready}, 32'd1);
            bus.awvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 1'b0;
    endtask

    task automatic drive_w(input int i, output bit ok);
        int n;
        bus.wid = b_wid[i]; bus.wdata = b_data[i]; bus.wstrob = b_strb[i]; bus.wlast = b_last[i];
        bus.wvalid = 1'b1;
        n = 0;
        while (bus.wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        ok = (bus.wready === 1'b1);
        if (!ok) begin
            check("w_timeout", {31'd0, bus.wready}, 32'd1);
            bus.wvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.wvalid = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bhold,
                             input bit keep_aw, input logic [1:0] lit_resp);
        bit err, ok;
        bit we [16];
        logic [31:0] a;
        int n;
        err = (size > 3'd2) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
        for (int i = 0; i <= int'(len); i++) begin
            a = model_addr(addr, size, len, burst, i);
            if (a >= 32'(4 * MEM_DEPTH) || b_wid[i] != id || b_last[i] != (i == int'(len))) err = 1'b1;
            we[i] = !err;
        end
        exp_bid   = id;
        exp_bresp = err ? 2'b10 : 2'b00;
        drive_aw(id, addr, len, size, burst, ok);
        if (!ok) return;
        for (int i = 0; i <= int'(len); i++) begin
            drive_w(i, ok);
            if (!ok) return;
            if (we[i]) model_write(i, model_addr(addr, size, len, burst, i));
            if (i < int'(len)) begin
                check("b_early", {31'd0, bus.bvalid}, 32'd0);
            end else begin
                check("b_latency", {31'd0, bus.bvalid}, 32'd1);
                check("bresp_lit", {30'd0, bus.bresp}, {30'd0, lit_resp});
                check("bid_lit", {28'd0, bus.bid}, {28'd0, id});
            end
        end
        for (int h = 0; h < bhold; h++) begin
            if (keep_aw) bus.awvalid = 1'b1;
            @(negedge aclk);
            check("hold_bvalid", {31'd0, bus.bvalid}, 32'd1);
            check("hold_awready", {31'd0, bus.awready}, 32'd0);
            check("hold_wready", {31'd0, bus.wready}, 32'd0);
        end
        bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
        if (bus.bvalid !== 1'b1) begin
            check("b_timeout", {31'd0, bus.bvalid}, 32'd1);
            bus.bready = 1'b0;
            return;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.bready = 1'b0;
        check("b_clear", {31'd0, bus.bvalid}, 32'd0);
        check("aw_reopen", {31'd0, bus.awready}, 32'd1);
    endtask

    task automatic dbg_read(input logic [7:0] idx, input logic [31:0] exp, input string name);
        dbg_force_addr = idx;
        dbg_force = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check(name, dbg_data, exp);
        dbg_force = 1'b0;
    endtask

    // Debug address sweep, overridden by directed reads.
    initial begin
        dbg_addr = '0;
        forever begin
            @(negedge aclk);
            dbg_addr = dbg_force ? dbg_force_addr : dbg_addr + 8'd1;
        end
    end

    // Per-cycle compare of debug data, B fields and ready exclusivity.
    initial begin : cmp
        logic [31:0] e;
        bit v;
        forever begin
            @(posedge aclk);
            e = model_mem[dbg_addr];
            v = !arst && known[dbg_addr];
            @(negedge aclk);
            if (v && !arst) check("dbg_sweep", dbg_data, e);
            if (!arst && bus.bvalid) begin
                check("b_id", {28'd0, bus.bid}, {28'd0, exp_bid});
                check("b_resp", {30'd0, bus.bresp}, {30'd0, exp_bresp});
            end
            if (!arst) check("ready_excl", {31'd0, bus.awready && (bus.wready || bus.bvalid)}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < MEM_DEPTH; i++) begin model_mem[i] = '0; known[i] = 1'b0; end
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awbrust = '0;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrob = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        arst = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_awready", {31'd0, bus.awready}, 32'd0);
        check("rst_wready", {31'd0, bus.wready}, 32'd0);
        check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
        check("rst_bid", {28'd0, bus.bid}, 32'd0);
        check("rst_bresp", {30'd0, bus.bresp}, 32'd0);
        check("rst_dbg", dbg_data, 32'd0);
        arst = 1'b0;
        check("rel_awready0", {31'd0, bus.awready}, 32'd0);
        @(negedge aclk);
        check("rel_awready1", {31'd0, bus.awready}, 32'd1);

        // Fill memory with word index tags.
        for (int w = 0; w < 16; w++) begin
            prep(4'd0, 4'd15, 32'hC0DE_0000 + 32'(w * 16));
            run_burst(4'd0, 32'(w * 64), 4'd15, 3'd2, 2'b01, 0, 1'b0, 2'b00);
        end
        dbg_read(8'd7, 32'hC0DE_0007, "prefill_w7");

        // INCR single beat.
        prep(4'd3, 4'd0, 32'hDEAD_BEEF);
        run_burst(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 0, 1'b0, 2'b00);
        dbg_read(8'd4, 32'hDEAD_BEEF, "incr1_w4");

        // INCR 4 beats with a partial strobe over all-ones.
        prep(4'd1, 4'd3, 32'd0);
        for (int i = 0; i < 4; i++) b_data[i] = 32'hFFFF_FFFF;
        run_burst(4'd1, 32'h20, 4'd3, 3'd2, 2'b01, 0, 1'b0, 2'b00);
        prep(4'd2, 4'd3, 32'd0);
        for (int i = 0; i < 4; i++) b_data[i] = 32'h1111_1111 * 32'(i + 1);
        b_strb[2] = 4'b0011;
        run_burst(4'd2, 32'h20, 4'd3, 3'd2, 2'b01, 0, 1'b0, 2'b00);
        dbg_read(8'd8,  32'h1111_1111, "incr4_w8");
        dbg_read(8'd9,  32'h2222_2222, "incr4_w9");
        dbg_read(8'd10, 32'hFFFF_3333, "incr4_w10");
        dbg_read(8'd11, 32'h4444_4444, "incr4_w11");

        // WRAP 4 beats from 0x38.
        prep(4'd4, 4'd3, 32'hA000_0000);
        run_burst(4'd4, 32'h38, 4'd3, 3'd2, 2'b10, 0, 1'b0, 2'b00);
        dbg_read(8'd14, 32'hA000_0000, "wrap_w14");
        dbg_read(8'd15, 32'hA000_0001, "wrap_w15");
        dbg_read(8'd12, 32'hA000_0002, "wrap_w12");
        dbg_read(8'd13, 32'hA000_0003, "wrap_w13");

        // WRAP with illegal length.
        prep(4'd4, 4'd2, 32'hBAD0_0000);
        run_burst(4'd4, 32'h38, 4'd2, 3'd2, 2'b10, 0, 1'b0, 2'b10);
        dbg_read(8'd14, 32'hA000_0000, "wrap3_w14");
        dbg_read(8'd12, 32'hA000_0002, "wrap3_w12");

        // Early wlast on beat 1.
        prep(4'd6, 4'd3, 32'h7777_0000);
        b_last[1] = 1'b1;
        run_burst(4'd6, 32'h50, 4'd3, 3'd2, 2'b01, 0, 1'b0, 2'b10);
        dbg_read(8'd20, 32'h7777_0000, "wlast_w20");
        dbg_read(8'd21, 32'hC0DE_0015, "wlast_w21");
        dbg_read(8'd23, 32'hC0DE_0017, "wlast_w23");

        // Run off the end of memory.
        prep(4'd7, 4'd1, 32'h1234_5678);
        run_burst(4'd7, 32'h3FC, 4'd1, 3'd2, 2'b01, 0, 1'b0, 2'b10);
        dbg_read(8'd255, 32'h1234_5678, "oor_w255");
        dbg_read(8'd0, 32'hC0DE_0000, "oor_w0");

        // wid mismatch.
        prep(4'd9, 4'd0, 32'h5151_5151);
        b_wid[0] = 4'd8;
        run_burst(4'd9, 32'h78, 4'd0, 3'd2, 2'b01, 0, 1'b0, 2'b10);
        dbg_read(8'd30, 32'hC0DE_001E, "wid_w30");

        // Oversized beat.
        prep(4'd12, 4'd0, 32'h9999_9999);
        run_burst(4'd12, 32'h80, 4'd0, 3'd3, 2'b01, 0, 1'b0, 2'b10);
        dbg_read(8'd32, 32'hC0DE_0020, "size3_w32");

        // B backpressure with a waiting AW, then a FIXED burst.
        prep(4'd10, 4'd1, 32'h5555_0000);
        run_burst(4'd10, 32'h100, 4'd1, 3'd2, 2'b01, 5, 1'b1, 2'b00);
        prep(4'd11, 4'd2, 32'h6666_0000);
        run_burst(4'd11, 32'h108, 4'd2, 3'd2, 2'b00, 0, 1'b0, 2'b00);
        check("aw_wait_after_b", 32'(aw_n_last), 32'd0);
        dbg_read(8'd64, 32'h5555_0000, "bp_w64");
        dbg_read(8'd65, 32'h5555_0001, "bp_w65");
        dbg_read(8'd66, 32'h6666_0002, "fixed_w66");
        dbg_read(8'd67, 32'hC0DE_0043, "fixed_w67");

        // Reset in the middle of a burst.
        prep(4'd5, 4'd3, 32'h0BAD_0000);
        drive_aw(4'd5, 32'hA0, 4'd3, 3'd2, 2'b01, ok);
        for (int i = 0; i < 2; i++) begin
            if (ok) begin
                drive_w(i, ok);
                if (ok) model_write(i, 32'hA0 + 32'(4 * i));
            end
        end
        check("pre_rst_wready", {31'd0, bus.wready}, 32'd1);
        #2 arst = 1'b1;
        #1;
        check("async_awready", {31'd0, bus.awready}, 32'd0);
        check("async_wready", {31'd0, bus.wready}, 32'd0);
        check("async_bvalid", {31'd0, bus.bvalid}, 32'd0);
        repeat (2) @(negedge aclk);
        arst = 1'b0;
        check("rel2_awready0", {31'd0, bus.awready}, 32'd0);
        @(negedge aclk);
        check("rel2_awready1", {31'd0, bus.awready}, 32'd1);
        prep(4'd6, 4'd1, 32'h3C3C_0000);
        run_burst(4'd6, 32'hC8, 4'd1, 3'd2, 2'b01, 0, 1'b0, 2'b00);
        dbg_read(8'd40, 32'h0BAD_0000, "rst_w40");
        dbg_read(8'd42, 32'hC0DE_002A, "rst_w42");
        dbg_read(8'd50, 32'h3C3C_0000, "rst_w50");

        repeat (4) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
